// File: rtl/mcpu_sb_pkg.sv
// Shared definitions for the register/predicate scoreboard: sizes, link register, one-hot decode helpers.
package mcpu_sb_pkg;

   localparam int          NUM_GPRS  = 32;
   localparam int          NUM_PREDS = 3;
   localparam logic [4:0]  LINK_REG  = 5'd31;
   localparam logic [1:0]  BAD_PRED  = 2'd3;

   typedef logic [NUM_GPRS-1:0]  gpr_vec_t;
   typedef logic [NUM_PREDS-1:0] pred_vec_t;

   function automatic gpr_vec_t vec_of(input logic [4:0] num, input logic en);
      gpr_vec_t v;
      v = '0;
      if (en) v[num] = 1'b1;
      return v;
   endfunction

   // Predicate index 3 has no architectural entry and decodes to nothing.
   function automatic pred_vec_t pvec_of(input logic [1:0] num, input logic en);
      pred_vec_t v;
      v = '0;
      if (en && (num != BAD_PRED)) v[num] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/mcpu_scoreboard_if.sv
// Issue, writeback and scoreboard-status bundle between decode/writeback and the scoreboard.
interface mcpu_scoreboard_if
   import mcpu_sb_pkg::*;
   ;
   logic             iss_valid;
   logic             iss_rd_we;
   logic [4:0]       iss_rd_num;
   logic             iss_link_we;
   logic             iss_pred_we;
   logic [1:0]       iss_pred_num;
   logic             wb0_valid;
   logic             wb0_rd_we;
   logic [4:0]       wb0_rd_num;
   logic             wb0_pred_we;
   logic [1:0]       wb0_pred_num;
   logic             wb1_valid;
   logic             wb1_rd_we;
   logic [4:0]       wb1_rd_num;
   logic             wb1_pred_we;
   logic [1:0]       wb1_pred_num;
   gpr_vec_t         reg_scoreboard;
   pred_vec_t        pred_scoreboard;
   logic             idle;
   logic [5:0]       pending_cnt;
   logic             err_double_set;
   logic             err_spurious_clr;
   logic             err_bad_pred;

   modport master (
      output iss_valid, iss_rd_we, iss_rd_num, iss_link_we, iss_pred_we, iss_pred_num,
             wb0_valid, wb0_rd_we, wb0_rd_num, wb0_pred_we, wb0_pred_num,
             wb1_valid, wb1_rd_we, wb1_rd_num, wb1_pred_we, wb1_pred_num,
      input  reg_scoreboard, pred_scoreboard, idle, pending_cnt,
             err_double_set, err_spurious_clr, err_bad_pred
   );

   modport slave (
      input  iss_valid, iss_rd_we, iss_rd_num, iss_link_we, iss_pred_we, iss_pred_num,
             wb0_valid, wb0_rd_we, wb0_rd_num, wb0_pred_we, wb0_pred_num,
             wb1_valid, wb1_rd_we, wb1_rd_num, wb1_pred_we, wb1_pred_num,
      output reg_scoreboard, pred_scoreboard, idle, pending_cnt,
             err_double_set, err_spurious_clr, err_bad_pred
   );

endinterface

// File: rtl/mcpu_popcount35.sv
// Combinational population count of the 35 pending bits (32 GPRs + 3 predicates).
module mcpu_popcount35 (
   input  logic [34:0] vec_i,
   output logic [5:0]  cnt_o
);

   always_comb begin
      cnt_o = '0;
      for (int i = 0; i < 35; i++) begin
         cnt_o = cnt_o + 6'(vec_i[i]);
      end
   end

endmodule

// File: rtl/mcpu_scoreboard.sv
// Pending-write scoreboard for GPRs and predicates: set at issue, cleared by two writeback ports.
// Set is visible next cycle; clear is visible same cycle when WB_BYPASS=1, else next cycle.
module mcpu_scoreboard
   import mcpu_sb_pkg::*;
#(
   parameter bit WB_BYPASS = 1'b1
) (
   input  logic                clkrst_core_clk,
   input  logic                clkrst_core_rst,
   mcpu_scoreboard_if.slave    sb
);

   gpr_vec_t  pend_reg_q, pend_reg_d;
   pred_vec_t pend_pred_q, pend_pred_d;
   logic      err_ds_q, err_ds_d;
   logic      err_sc_q, err_sc_d;
   logic      err_bp_q, err_bp_d;

   gpr_vec_t  set_reg, clr0_reg, clr1_reg, clr_reg, out_reg;
   pred_vec_t set_pred, clr0_pred, clr1_pred, clr_pred, out_pred;
   logic      bad_pred;

   always_comb begin
      set_reg   = vec_of(sb.iss_rd_num, sb.iss_valid & sb.iss_rd_we)
                | vec_of(LINK_REG, sb.iss_valid & sb.iss_link_we);
      set_pred  = pvec_of(sb.iss_pred_num, sb.iss_valid & sb.iss_pred_we);
      clr0_reg  = vec_of(sb.wb0_rd_num, sb.wb0_valid & sb.wb0_rd_we);
      clr1_reg  = vec_of(sb.wb1_rd_num, sb.wb1_valid & sb.wb1_rd_we);
      clr0_pred = pvec_of(sb.wb0_pred_num, sb.wb0_valid & sb.wb0_pred_we);
      clr1_pred = pvec_of(sb.wb1_pred_num, sb.wb1_valid & sb.wb1_pred_we);
      clr_reg   = clr0_reg | clr1_reg;
      clr_pred  = clr0_pred | clr1_pred;
      bad_pred  = (sb.iss_valid & sb.iss_pred_we & (sb.iss_pred_num == BAD_PRED))
                | (sb.wb0_valid & sb.wb0_pred_we & (sb.wb0_pred_num == BAD_PRED))
                | (sb.wb1_valid & sb.wb1_pred_we & (sb.wb1_pred_num == BAD_PRED));

      // Set wins over clear: the clear retires an older write to the same entry.
      pend_reg_d  = (pend_reg_q & ~clr_reg) | set_reg;
      pend_pred_d = (pend_pred_q & ~clr_pred) | set_pred;

      err_ds_d = err_ds_q | (|(set_reg & pend_reg_q & ~clr_reg))
                          | (|(set_pred & pend_pred_q & ~clr_pred));
      err_sc_d = err_sc_q | (|(clr_reg & ~pend_reg_q)) | (|(clr_pred & ~pend_pred_q))
                          | (|(clr0_reg & clr1_reg)) | (|(clr0_pred & clr1_pred));
      err_bp_d = err_bp_q | bad_pred;

      if (WB_BYPASS) begin
         out_reg  = pend_reg_q & ~clr_reg;
         out_pred = pend_pred_q & ~clr_pred;
      end else begin
         out_reg  = pend_reg_q;
         out_pred = pend_pred_q;
      end
   end

   always_ff @(posedge clkrst_core_clk) begin
      if (clkrst_core_rst) begin
         pend_reg_q  <= '0;
         pend_pred_q <= '0;
         err_ds_q    <= 1'b0;
         err_sc_q    <= 1'b0;
         err_bp_q    <= 1'b0;
      end else begin
         pend_reg_q  <= pend_reg_d;
         pend_pred_q <= pend_pred_d;
         err_ds_q    <= err_ds_d;
         err_sc_q    <= err_sc_d;
         err_bp_q    <= err_bp_d;
      end
   end

   mcpu_popcount35 u_popcount (
      .vec_i ({out_pred, out_reg}),
      .cnt_o (sb.pending_cnt)
   );

   assign sb.reg_scoreboard   = out_reg;
   assign sb.pred_scoreboard  = out_pred;
   assign sb.idle             = ~(|{out_pred, out_reg});
   assign sb.err_double_set   = err_ds_q;
   assign sb.err_spurious_clr = err_sc_q;
   assign sb.err_bad_pred     = err_bp_q;

endmodule

// File: tb/tb_mcpu_scoreboard.sv
// Bench for mcpu_scoreboard: bypass and non-bypass instances share one stimulus stream, checked every cycle.
module tb_mcpu_scoreboard;
   import mcpu_sb_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   mcpu_scoreboard_if if_b ();
   mcpu_scoreboard_if if_n ();

   assign if_n.iss_valid    = if_b.iss_valid;
   assign if_n.iss_rd_we    = if_b.iss_rd_we;
   assign if_n.iss_rd_num   = if_b.iss_rd_num;
   assign if_n.iss_link_we  = if_b.iss_link_we;
   assign if_n.iss_pred_we  = if_b.iss_pred_we;
   assign if_n.iss_pred_num = if_b.iss_pred_num;
   assign if_n.wb0_valid    = if_b.wb0_valid;
   assign if_n.wb0_rd_we    = if_b.wb0_rd_we;
   assign if_n.wb0_rd_num   = if_b.wb0_rd_num;
   assign if_n.wb0_pred_we  = if_b.wb0_pred_we;
   assign if_n.wb0_pred_num = if_b.wb0_pred_num;
   assign if_n.wb1_valid    = if_b.wb1_valid;
   assign if_n.wb1_rd_we    = if_b.wb1_rd_we;
   assign if_n.wb1_rd_num   = if_b.wb1_rd_num;
   assign if_n.wb1_pred_we  = if_b.wb1_pred_we;
   assign if_n.wb1_pred_num = if_b.wb1_pred_num;

   mcpu_scoreboard #(.WB_BYPASS(1'b1)) dut_b (
      .clkrst_core_clk (clk),
      .clkrst_core_rst (rst),
      .sb              (if_b.slave)
   );

   mcpu_scoreboard #(.WB_BYPASS(1'b0)) dut_n (
      .clkrst_core_clk (clk),
      .clkrst_core_rst (rst),
      .sb              (if_n.slave)
   );

   int n_chk  = 0;
   int n_fail = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference model: plain per-entry pending flags and sticky error bits.
   bit m_reg[32];
   bit m_pred[3];
   bit m_eds, m_esc, m_ebp;

   task automatic clr_in();
      if_b.iss_valid = 0; if_b.iss_rd_we = 0; if_b.iss_rd_num = 0; if_b.iss_link_we = 0;
      if_b.iss_pred_we = 0; if_b.iss_pred_num = 0;
      if_b.wb0_valid = 0; if_b.wb0_rd_we = 0; if_b.wb0_rd_num = 0; if_b.wb0_pred_we = 0; if_b.wb0_pred_num = 0;
      if_b.wb1_valid = 0; if_b.wb1_rd_we = 0; if_b.wb1_rd_num = 0; if_b.wb1_pred_we = 0; if_b.wb1_pred_num = 0;
   endtask

   task automatic model_reset();
      for (int i = 0; i < 32; i++) m_reg[i] = 0;
      for (int i = 0; i < 3; i++) m_pred[i] = 0;
      m_eds = 0; m_esc = 0; m_ebp = 0;
   endtask

   // One clock: check both DUTs at the falling edge, then advance the model at the rising edge.
   task automatic cyc();
      bit s_r[32], c_r[32], s_p[3], c_p[3];
      bit c0, c1, ev_ds, ev_sc, ev_bp;
      logic [31:0] eb_reg, en_reg;
      logic [31:0] eb_pred, en_pred;
      int cb, cn;
      @(negedge clk);
      ev_ds = 0; ev_sc = 0;
      eb_reg = 0; en_reg = 0; eb_pred = 0; en_pred = 0; cb = 0; cn = 0;
      for (int i = 0; i < 32; i++) begin
         s_r[i] = if_b.iss_valid && ((if_b.iss_rd_we && if_b.iss_rd_num == i) ||
                                     (if_b.iss_link_we && i == 31));
         c0 = if_b.wb0_valid && if_b.wb0_rd_we && if_b.wb0_rd_num == i;
         c1 = if_b.wb1_valid && if_b.wb1_rd_we && if_b.wb1_rd_num == i;
         c_r[i] = c0 || c1;
         if (c0 && c1) ev_sc = 1;
         if (c_r[i] && !m_reg[i]) ev_sc = 1;
         if (s_r[i] && m_reg[i] && !c_r[i]) ev_ds = 1;
         eb_reg[i] = m_reg[i] && !c_r[i];
         en_reg[i] = m_reg[i];
         cb += int'(eb_reg[i]);
         cn += int'(en_reg[i]);
      end
      for (int i = 0; i < 3; i++) begin
         s_p[i] = if_b.iss_valid && if_b.iss_pred_we && if_b.iss_pred_num == i;
         c0 = if_b.wb0_valid && if_b.wb0_pred_we && if_b.wb0_pred_num == i;
         c1 = if_b.wb1_valid && if_b.wb1_pred_we && if_b.wb1_pred_num == i;
         c_p[i] = c0 || c1;
         if (c0 && c1) ev_sc = 1;
         if (c_p[i] && !m_pred[i]) ev_sc = 1;
         if (s_p[i] && m_pred[i] && !c_p[i]) ev_ds = 1;
         eb_pred[i] = m_pred[i] && !c_p[i];
         en_pred[i] = m_pred[i];
         cb += int'(eb_pred[i]);
         cn += int'(en_pred[i]);
      end
      ev_bp = (if_b.iss_valid && if_b.iss_pred_we && if_b.iss_pred_num == 3) ||
              (if_b.wb0_valid && if_b.wb0_pred_we && if_b.wb0_pred_num == 3) ||
              (if_b.wb1_valid && if_b.wb1_pred_we && if_b.wb1_pred_num == 3);

      check_eq("byp.reg_sb",  if_b.reg_scoreboard, eb_reg);
      check_eq("byp.pred_sb", 32'(if_b.pred_scoreboard), eb_pred);
      check_eq("byp.cnt",     32'(if_b.pending_cnt), 32'(cb));
      check_eq("byp.idle",    32'(if_b.idle), 32'(cb == 0));
      check_eq("nob.reg_sb",  if_n.reg_scoreboard, en_reg);
      check_eq("nob.pred_sb", 32'(if_n.pred_scoreboard), en_pred);
      check_eq("nob.cnt",     32'(if_n.pending_cnt), 32'(cn));
      check_eq("nob.idle",    32'(if_n.idle), 32'(cn == 0));
      check_eq("byp.err_ds",  32'(if_b.err_double_set), 32'(m_eds));
      check_eq("byp.err_sc",  32'(if_b.err_spurious_clr), 32'(m_esc));
      check_eq("byp.err_bp",  32'(if_b.err_bad_pred), 32'(m_ebp));
      check_eq("nob.err_ds",  32'(if_n.err_double_set), 32'(m_eds));
      check_eq("nob.err_sc",  32'(if_n.err_spurious_clr), 32'(m_esc));
      check_eq("nob.err_bp",  32'(if_n.err_bad_pred), 32'(m_ebp));

      @(posedge clk);
      if (rst) begin
         model_reset();
      end else begin
         for (int i = 0; i < 32; i++) m_reg[i] = (m_reg[i] && !c_r[i]) || s_r[i];
         for (int i = 0; i < 3; i++) m_pred[i] = (m_pred[i] && !c_p[i]) || s_p[i];
         m_eds |= ev_ds; m_esc |= ev_sc; m_ebp |= ev_bp;
      end
      #1;
   endtask

   function automatic logic [4:0] pick_rd();
      int st;
      st = $urandom_range(0, 31);
      for (int k = 0; k < 32; k++) if (m_reg[(st + k) % 32]) return 5'((st + k) % 32);
      return 5'(st);
   endfunction

   initial begin
      clr_in();
      rst = 1;
      @(posedge clk); #1;
      model_reset();
      cyc();
      check_eq("rst.idle", 32'(if_b.idle), 32'd1);
      rst = 0;

      // Issue r5, retire it three cycles later on wb0.
      if_b.iss_valid = 1; if_b.iss_rd_we = 1; if_b.iss_rd_num = 5; cyc();
      clr_in();
      check_eq("rd5.set", 32'(if_b.reg_scoreboard[5]), 32'd1);
      cyc(); cyc();
      if_b.wb0_valid = 1; if_b.wb0_rd_we = 1; if_b.wb0_rd_num = 5;
      #1 check_eq("rd5.byp_clr", 32'(if_b.reg_scoreboard[5]), 32'd0);
      check_eq("rd5.nob_hold", 32'(if_n.reg_scoreboard[5]), 32'd1);
      cyc(); clr_in(); cyc();

      // Re-issue r7 in the cycle its older write retires.
      if_b.iss_valid = 1; if_b.iss_rd_we = 1; if_b.iss_rd_num = 7; cyc();
      if_b.wb1_valid = 1; if_b.wb1_rd_we = 1; if_b.wb1_rd_num = 7; cyc();
      clr_in();
      check_eq("rd7.pend", 32'(if_n.reg_scoreboard[7]), 32'd1);
      check_eq("rd7.no_err", 32'(if_b.err_double_set), 32'd0);
      if_b.wb0_valid = 1; if_b.wb0_rd_we = 1; if_b.wb0_rd_num = 7; cyc();
      clr_in();

      // Branch-with-link plus predicate 2, then both retire together.
      if_b.iss_valid = 1; if_b.iss_link_we = 1; if_b.iss_pred_we = 1; if_b.iss_pred_num = 2; cyc();
      clr_in();
      check_eq("link.r31", 32'(if_b.reg_scoreboard[31]), 32'd1);
      check_eq("link.pred", 32'(if_b.pred_scoreboard), 32'h4);
      if_b.wb0_valid = 1; if_b.wb0_pred_we = 1; if_b.wb0_pred_num = 2;
      if_b.wb1_valid = 1; if_b.wb1_rd_we = 1; if_b.wb1_rd_num = 31; cyc();
      clr_in();
      check_eq("link.idle", 32'(if_n.idle), 32'd1);

      // Both ports retire r9 in one cycle.
      if_b.iss_valid = 1; if_b.iss_rd_we = 1; if_b.iss_rd_num = 9; cyc();
      clr_in();
      if_b.wb0_valid = 1; if_b.wb0_rd_we = 1; if_b.wb0_rd_num = 9;
      if_b.wb1_valid = 1; if_b.wb1_rd_we = 1; if_b.wb1_rd_num = 9; cyc();
      clr_in();
      check_eq("rd9.err_sc", 32'(if_b.err_spurious_clr), 32'd1);
      cyc(); cyc();
      check_eq("rd9.sticky", 32'(if_n.err_spurious_clr), 32'd1);
      rst = 1; cyc(); rst = 0;
      check_eq("rd9.rst_err", 32'(if_b.err_spurious_clr), 32'd0);

      // Predicate index 3, then a double issue of r4.
      if_b.iss_valid = 1; if_b.iss_pred_we = 1; if_b.iss_pred_num = 3; cyc();
      clr_in();
      check_eq("bp.pred", 32'(if_b.pred_scoreboard), 32'd0);
      check_eq("bp.err", 32'(if_b.err_bad_pred), 32'd1);
      if_b.iss_valid = 1; if_b.iss_rd_we = 1; if_b.iss_rd_num = 4; cyc(); cyc();
      clr_in();
      check_eq("ds.err", 32'(if_b.err_double_set), 32'd1);
      rst = 1; cyc(); rst = 0;

      // Fill every entry, then reset under concurrent traffic.
      for (int i = 0; i < 32; i++) begin
         clr_in();
         if_b.iss_valid = 1; if_b.iss_rd_we = 1; if_b.iss_rd_num = 5'(i);
         if (i < 3) begin if_b.iss_pred_we = 1; if_b.iss_pred_num = 2'(i); end
         cyc();
      end
      clr_in();
      check_eq("fill.cnt", 32'(if_b.pending_cnt), 32'd35);
      rst = 1;
      if_b.iss_valid = 1; if_b.iss_rd_we = 1; if_b.iss_rd_num = 3;
      if_b.wb0_valid = 1; if_b.wb0_rd_we = 1; if_b.wb0_rd_num = 4;
      cyc();
      rst = 0; clr_in();
      check_eq("midrst.cnt", 32'(if_n.pending_cnt), 32'd0);
      cyc();

      // Randomised traffic with occasional resets.
      for (int n = 0; n < 2000; n++) begin
         rst = ($urandom_range(0, 59) == 0);
         if_b.iss_valid    = 1'($urandom_range(0, 1));
         if_b.iss_rd_we    = 1'($urandom_range(0, 1));
         if_b.iss_rd_num   = 5'($urandom_range(0, 31));
         if_b.iss_link_we  = ($urandom_range(0, 7) == 0);
         if_b.iss_pred_we  = 1'($urandom_range(0, 1));
         if_b.iss_pred_num = ($urandom_range(0, 19) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
         if_b.wb0_valid    = 1'($urandom_range(0, 1));
         if_b.wb0_rd_we    = 1'($urandom_range(0, 1));
         if_b.wb0_rd_num   = ($urandom_range(0, 3) != 0) ? pick_rd() : 5'($urandom_range(0, 31));
         if_b.wb0_pred_we  = 1'($urandom_range(0, 1));
         if_b.wb0_pred_num = 2'($urandom_range(0, 2));
         if_b.wb1_valid    = 1'($urandom_range(0, 1));
         if_b.wb1_rd_we    = 1'($urandom_range(0, 1));
         if_b.wb1_rd_num   = ($urandom_range(0, 3) != 0) ? pick_rd() : 5'($urandom_range(0, 31));
         if_b.wb1_pred_we  = 1'($urandom_range(0, 1));
         if_b.wb1_pred_num = 2'($urandom_range(0, 2));
         cyc();
      end
      rst = 0; clr_in();
      cyc();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/mcpu_scoreboard.md
Name: mcpu_scoreboard

Overview:
- Tracks outstanding writes to the 32 GPRs and 3 predicates for the in-order core.
- Produces reg_scoreboard[31:0] and pred_scoreboard[2:0], which the decode stage consumes to generate stall.
- Bits are set when decode issues a writing instruction and cleared by up to two writeback ports (ALU pipe, LSU pipe).
- Also provides a drain/idle indication for exception and interrupt entry, plus sticky protocol-error flags for verification.

Parameters:
- WB_BYPASS, 1: when 1, a writeback clear is visible on the scoreboard outputs in the same cycle it arrives; when 0, it is visible the next cycle.
- NUM_PREDS, 3: number of architectural predicates; the predicate index is 2 bits wide.

Ports:
- clkrst_core_clk  in  1  core clock
- clkrst_core_rst  in  1  synchronous, active-high reset
- iss_valid  in  1  decode is issuing an instruction this cycle (decode has already applied its own stall)
- iss_rd_we  in  1  issued instruction writes GPR iss_rd_num
- iss_rd_num  in  5  destination GPR
- iss_link_we  in  1  issued branch-with-link writes r31
- iss_pred_we  in  1  issued instruction writes predicate iss_pred_num
- iss_pred_num  in  2  destination predicate
- wb0_valid, wb1_valid  in  1 each  writeback port valid
- wb0_rd_we, wb1_rd_we  in  1 each  port retires a GPR write
- wb0_rd_num, wb1_rd_num  in  5 each  retired GPR
- wb0_pred_we, wb1_pred_we  in  1 each  port retires a predicate write
- wb0_pred_num, wb1_pred_num  in  2 each  retired predicate
- reg_scoreboard  out  32  pending GPR writes
- pred_scoreboard  out  3  pending predicate writes
- idle  out  1  no pending GPR or predicate write
- pending_cnt  out  6  population count of pending bits (GPR plus predicate, 0..35)
- err_double_set  out  1  sticky: issue targeted an already-pending entry
- err_spurious_clr  out  1  sticky: writeback targeted a non-pending entry, or both ports cleared the same entry in one cycle
- err_bad_pred  out  1  sticky: issue or writeback used predicate index 3

Behaviour:
- State: pend_reg[31:0], pend_pred[2:0], and the three sticky error flags, all registered.
- Reset: all state is 0. The outputs therefore reset to reg_scoreboard=0, pred_scoreboard=0, idle=1, pending_cnt=0, all err flags 0. Reset takes priority over every other input in the same cycle.
- Set vector S:
  - iss_valid&iss_rd_we sets bit iss_rd_num.
  - iss_valid&iss_link_we sets bit 31.
  - iss_valid&iss_pred_we sets predicate bit iss_pred_num, only when iss_pred_num<3.
  - An issue without iss_valid has no effect.
- Clear vector C: for each port k, wbk_valid&wbk_rd_we clears wbk_rd_num, and wbk_valid&wbk_pred_we clears wbk_pred_num when it is <3.
- Next state: pend_next = (pend & ~C) | S. A set wins over a clear on the same bit in the same cycle, because the clear retires an older write.
- Output:
  - WB_BYPASS=1: reg_scoreboard = pend_reg & ~C_reg. The set takes effect the next cycle. Result: 0-cycle clear latency, 1-cycle set latency.
  - WB_BYPASS=0: outputs equal the registered state. Result: 1-cycle latency for both set and clear.
  - pred_scoreboard follows the same rule.
- idle and pending_cnt are derived from the same vectors as the scoreboard outputs, i.e. they are bypass-consistent.
- Error flags (each sets the cycle after the triggering event and stays set until reset):
  - err_double_set: any S bit whose pend bit is 1 and is not simultaneously cleared.
  - err_spurious_clr: any C bit whose pend bit is 0; or port0 and port1 clearing the same bit in one cycle.
  - err_bad_pred: predicate index 3 with a we. The state update for that predicate is suppressed.
- iss_rd_we and iss_link_we both targeting r31 in the same cycle is a single set, not an error.
- No flush input: squashed instructions never issue, so drain happens through normal writeback.

Decomposition:
- Shared package mcpu_sb_pkg holds:
  - NUM_GPRS=32, NUM_PREDS=3, LINK_REG=5'd31
  - the decode helper function vec_of(num, en), which returns a one-hot vector gated by en
- One natural sub-module: mcpu_popcount35, a combinational popcount for pending_cnt.

Test Plan:
- Reset, then issue rd=5 at cycle 1 -> reg_scoreboard[5]=1 from cycle 2, idle=0, pending_cnt=1. wb0 rd=5 at cycle 4 -> with WB_BYPASS=1, bit 5 reads 0 in cycle 4; with WB_BYPASS=0, it reads 0 in cycle 5.
- Issue rd=7 and wb1 clears rd=7 in the same cycle (with pend[7]=1) -> pend[7] stays 1, no error flag.
- Issue branch-with-link plus pred_we pred=2 -> reg_scoreboard[31]=1 and pred_scoreboard=3'b100. Then wb0 clears pred 2 while wb1 clears r31 -> all bits 0, idle=1.
- wb0 and wb1 both clear rd=9 (pending) in one cycle -> pend[9]=0 and err_spurious_clr=1 next cycle. Stays 1 until reset; rst=1 -> all outputs return to their reset values.
- Issue pred_num=3 with pred_we -> pred_scoreboard unchanged, err_bad_pred=1. Issue rd=4 twice without a writeback in between -> err_double_set=1.
- Fill all 32 GPRs and 3 predicates -> pending_cnt=35. Assert reset mid-stream with concurrent issue and wb activity -> next cycle all pending bits are 0 and pending_cnt=0.
